pll_recfg_ctrl: RTL and testbench

Frequency-command front end for the IF synthesizer PLL. It accepts a requested IF code and computes the PLL M, N and C0 counter values that keep the VCO in its legal range. It then runs the full reconfiguration sequence: load, wait for the reconfig core, reset the PLL, confirm stable lock. It sits directly upstream of the IF synthesizer's PLL/reconfig instance and drives its `m`, `n`, `c0`, `strobe` and `pll_reset` inputs, and it owns the block-level `locked` indication.

---
 rtl/pll_recfg_pkg.sv | 38 +++
 rtl/c0_search.sv | 60 ++++++
 rtl/pll_recfg_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_pll_recfg_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_recfg_pkg.sv
// -----------------------------------------------------------------------------
// pll_recfg_pkg
//   Shared definitions for the IF synthesizer PLL reconfiguration controller:
//   counter widths, VCO and post-divider limits, the legal request code range,
//   the controller FSM state type and a code range helper.
// -----------------------------------------------------------------------------
package pll_recfg_pkg;

   // Widths of the PLL counter values and of the request code.
   localparam int unsigned M_W    = 11;
   localparam int unsigned N_W    = 8;
   localparam int unsigned C0_W   = 9;
   localparam int unsigned CODE_W = 9;

   // Lowest legal VCO frequency in MHz (equal to M at a 1 MHz PFD).
   localparam int unsigned VCO_MIN = 600;
   // Largest post-divider; a power of two.
   localparam int unsigned C0_MAX  = 256;

   // Legal request code range, inclusive.
   localparam int unsigned CODE_MIN = 3;
   localparam int unsigned CODE_MAX = 300;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_LOAD,
      ST_WAIT_BUSY_HI,
      ST_WAIT_BUSY_LO,
      ST_PLL_RST,
      ST_WAIT_LOCK
   } state_e;

   function automatic logic code_valid(input logic [CODE_W-1:0] code);
      return (code >= CODE_W'(CODE_MIN)) && (code <= CODE_W'(CODE_MAX));
   endfunction

endpackage

// File: rtl/c0_search.sv
// -----------------------------------------------------------------------------
// c0_search
//   Iterative post-divider search. On start it loads acc = code and c0 = 1,
//   then doubles both once per cycle until acc reaches VCO_MIN (or c0 reaches
//   C0_MAX). done is high while the result is valid; the result is held in
//   m_val / c0_val until the next start.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle launch, samples code
//   code       : requested code
//   done       : search finished, m_val / c0_val valid (drops the cycle after)
//   m_val      : VCO multiplier result (acc)
//   c0_val     : post-divider result
// -----------------------------------------------------------------------------
module c0_search
   import pll_recfg_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CODE_W-1:0] code,
   output logic              done,
   output logic [M_W-1:0]    m_val,
   output logic [C0_W-1:0]   c0_val
);

   logic              running;
   logic [M_W-1:0]    acc;
   logic [C0_W-1:0]   c0_acc;
   logic              need_double;

   // The C0_MAX guard keeps c0 inside its width even for an out-of-range code.
   assign need_double = (acc < M_W'(VCO_MIN)) && (c0_acc < C0_W'(C0_MAX));
   assign done        = running && !need_double;
   assign m_val       = acc;
   assign c0_val      = c0_acc;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         running <= 1'b0;
         acc     <= '0;
         c0_acc  <= '0;
      end else if (start) begin
         running <= 1'b1;
         acc     <= M_W'(code);
         c0_acc  <= C0_W'(1);
      end else if (running) begin
         if (need_double) begin
            acc    <= acc << 1;
            c0_acc <= c0_acc << 1;
         end else begin
            running <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pll_recfg_ctrl.sv
// -----------------------------------------------------------------------------
// pll_recfg_ctrl
//   Frequency-command front end for the IF synthesizer PLL. Validates a
//   requested code, computes M / N / C0 so the VCO stays in range, then runs
//   load -> wait reconfig core -> PLL reset -> stable-lock qualification.
//
//   Optional feature macro: PLL_RECFG_RETRY_EN
//     defined     : first WAIT_LOCK timeout of a request reruns the sequence
//                   from LOAD once; freq_err only on the second failure.
//     not defined : any timeout errors immediately.
//
// Ports
//   clk, rst_n      : 50 MHz clock, asynchronous active-low reset
//   if_freq         : requested code, sampled on freq_strobe
//   freq_strobe     : one-cycle request
//   busy            : reconfig core busy
//   pll_lock        : raw asynchronous PLL lock
//   m, n, c0        : PLL counter values
//   reconfig_strobe : one-cycle load command to the reconfig core
//   pll_reset       : PLL areset
//   locked          : programmed frequency active and stable
//   freq_err        : one-cycle pulse on rejected request or timeout
//   cur_freq        : last successfully locked code
// -----------------------------------------------------------------------------
module pll_recfg_ctrl
   import pll_recfg_pkg::*;
#(
   parameter int unsigned N_DIV        = 50,
   parameter int unsigned RESET_CYCLES = 8,
   parameter int unsigned LOCK_STABLE  = 16,
   parameter int unsigned LOCK_TIMEOUT = 65535
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CODE_W-1:0] if_freq,
   input  logic              freq_strobe,
   input  logic              busy,
   input  logic              pll_lock,
   output logic [M_W-1:0]    m,
   output logic [N_W-1:0]    n,
   output logic [C0_W-1:0]   c0,
   output logic              reconfig_strobe,
   output logic              pll_reset,
   output logic              locked,
   output logic              freq_err,
   output logic [CODE_W-1:0] cur_freq
);

   localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > RESET_CYCLES) ? LOCK_TIMEOUT : RESET_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned STB_W   = $clog2(LOCK_STABLE + 1);

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
   localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);

   state_e            state;
   logic [CODE_W-1:0] req_code;
   logic              pend_valid;
   logic [CODE_W-1:0] pend_code;
   logic [CNT_W-1:0]  wait_cnt;
   logic [STB_W-1:0]  stab_cnt;
   logic              lock_s1;
   logic              lock_s2;
`ifdef PLL_RECFG_RETRY_EN
   logic              retried;
`endif

   logic              strobe_ok;
   logic              launch;
   logic [CODE_W-1:0] launch_code;
   logic              search_done;
   logic [M_W-1:0]    search_m;
   logic [C0_W-1:0]   search_c0;

   // Launch decision is combinational so the search loads on the same edge
   // the FSM enters CALC. A fresh strobe in IDLE wins over a pending request.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      strobe_ok   = freq_strobe && code_valid(if_freq);
      launch      = 1'b0;
      launch_code = if_freq;
      if (state == ST_IDLE) begin
         if (strobe_ok) begin
            launch      = 1'b1;
            launch_code = if_freq;
         end else if (pend_valid) begin
            launch      = 1'b1;
            launch_code = pend_code;
         end
      end
   end

   c0_search u_c0_search (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (launch),
      .code   (launch_code),
      .done   (search_done),
      .m_val  (search_m),
      .c0_val (search_c0)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         m               <= '0;
         n               <= N_W'(N_DIV);
         c0              <= '0;
         reconfig_strobe <= 1'b0;
         pll_reset       <= 1'b0;
         locked          <= 1'b0;
         freq_err        <= 1'b0;
         cur_freq        <= '0;
         req_code        <= '0;
         // NOTE: the pending code is reset together with its valid flag; it is
         // a single control register, not a memory array.
         pend_valid      <= 1'b0;
         pend_code       <= '0;
         wait_cnt        <= '0;
         stab_cnt        <= '0;
         lock_s1         <= 1'b0;
         lock_s2         <= 1'b0;
`ifdef PLL_RECFG_RETRY_EN
         retried         <= 1'b0;
`endif
      end else begin
         reconfig_strobe <= 1'b0;
         freq_err        <= 1'b0;
         lock_s1         <= pll_lock;
         lock_s2         <= lock_s1;

         if (freq_strobe && !code_valid(if_freq)) begin
            freq_err <= 1'b1;
         end

         // One-deep pending slot; the newest valid request overwrites it.
         if ((state != ST_IDLE) && strobe_ok) begin
            pend_valid <= 1'b1;
            pend_code  <= if_freq;
         end

         case (state)
            ST_IDLE: begin
               // No automatic relock: a lost lock only drops the indication.
               if (locked && !lock_s2) begin
                  locked <= 1'b0;
               end
               if (launch) begin
                  state      <= ST_CALC;
                  req_code   <= launch_code;
                  pend_valid <= 1'b0;
`ifdef PLL_RECFG_RETRY_EN
                  retried    <= 1'b0;
`endif
               end
            end

            ST_CALC: begin
               if (search_done) begin
                  m               <= search_m;
                  c0              <= search_c0;
                  n               <= N_W'(N_DIV);
                  locked          <= 1'b0;
                  reconfig_strobe <= 1'b1;
                  state           <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               wait_cnt <= '0;
               state    <= ST_WAIT_BUSY_HI;
            end

            ST_WAIT_BUSY_HI: begin
               if (busy) begin
                  wait_cnt <= '0;
                  state    <= ST_WAIT_BUSY_LO;
               end else if (wait_cnt == TMO_LAST) begin
                  freq_err <= 1'b1;
                  locked   <= 1'b0;
                  state    <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            ST_WAIT_BUSY_LO: begin
               if (!busy) begin
                  wait_cnt  <= '0;
                  pll_reset <= 1'b1;
                  state     <= ST_PLL_RST;
               end else if (wait_cnt == TMO_LAST) begin
                  freq_err <= 1'b1;
                  locked   <= 1'b0;
                  state    <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            ST_PLL_RST: begin
               if (wait_cnt == RST_LAST) begin
                  pll_reset <= 1'b0;
                  wait_cnt  <= '0;
                  stab_cnt  <= '0;
                  state     <= ST_WAIT_LOCK;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            ST_WAIT_LOCK: begin
               // Any synchronized lock drop restarts the stability count.
               if (lock_s2) begin
                  stab_cnt <= stab_cnt + 1'b1;
               end else begin
                  stab_cnt <= '0;
               end

               if (lock_s2 && (stab_cnt == STB_LAST)) begin
                  locked   <= 1'b1;
                  cur_freq <= req_code;
                  state    <= ST_IDLE;
               end else if (wait_cnt == TMO_LAST) begin
`ifdef PLL_RECFG_RETRY_EN
                  if (!retried) begin
                     retried         <= 1'b1;
                     reconfig_strobe <= 1'b1;
                     state           <= ST_LOAD;
                  end else begin
                     freq_err <= 1'b1;
                     locked   <= 1'b0;
                     state    <= ST_IDLE;
                  end
`else
                  freq_err <= 1'b1;
                  locked   <= 1'b0;
                  state    <= ST_IDLE;
`endif
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pll_recfg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_recfg_ctrl
//   Self-checking bench for pll_recfg_ctrl. Expected reconfig loads and error
//   pulses are queued as requests are issued; a negedge monitor pops and
//   compares them whenever reconfig_strobe or freq_err fires. The bench plays
//   the reconfig core (busy) and the PLL (pll_lock).
// -----------------------------------------------------------------------------
module tb_pll_recfg_ctrl;

   localparam int unsigned TMO = 1000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [8:0]  if_freq = '0;
   logic        freq_strobe = 1'b0;
   logic        busy = 1'b0;
   logic        pll_lock = 1'b0;
   logic [10:0] m;
   logic [7:0]  n;
   logic [8:0]  c0;
   logic        reconfig_strobe;
   logic        pll_reset;
   logic        locked;
   logic        freq_err;
   logic [8:0]  cur_freq;

   pll_recfg_ctrl #(
      .N_DIV        (50),
      .RESET_CYCLES (8),
      .LOCK_STABLE  (16),
      .LOCK_TIMEOUT (TMO)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .if_freq         (if_freq),
      .freq_strobe     (freq_strobe),
      .busy            (busy),
      .pll_lock        (pll_lock),
      .m               (m),
      .n               (n),
      .c0              (c0),
      .reconfig_strobe (reconfig_strobe),
      .pll_reset       (pll_reset),
      .locked          (locked),
      .freq_err        (freq_err),
      .cur_freq        (cur_freq)
   );

   always #10 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic        is_err;
      logic [10:0] m;
      logic [8:0]  c0;
   } ev_t;

   ev_t exp_q[$];

   function automatic bit code_ok(input int code);
      return (code >= 3) && (code <= 300);
   endfunction

   function automatic ev_t model(input int code);
      ev_t e;
      int  acc;
      int  c;
      acc = code;
      c   = 1;
      while (acc < 600) begin
         acc = acc * 2;
         c   = c * 2;
      end
      e.is_err = 1'b0;
      e.m      = 11'(acc);
      e.c0     = 9'(c);
      return e;
   endfunction

   function automatic ev_t err_ev();
      ev_t e;
      e.is_err = 1'b1;
      e.m      = '0;
      e.c0     = '0;
      return e;
   endfunction

   int cyc = 0;
   int n_strobe = 0;
   int n_err = 0;
   int strobe_cyc = 0;
   int err_cyc = 0;
   int send_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic sb_check(input logic is_err);
      ev_t e;
      check(is_err ? "sb_err_expected" : "sb_strobe_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("sb_kind", 32'(is_err), 32'(e.is_err));
         if (!is_err) begin
            check("sb_m", 32'(m), 32'(e.m));
            check("sb_c0", 32'(c0), 32'(e.c0));
            check("sb_n", 32'(n), 50);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (reconfig_strobe === 1'b1) begin
            n_strobe++;
            strobe_cyc = cyc;
            sb_check(1'b0);
         end
         if (freq_err === 1'b1) begin
            n_err++;
            err_cyc = cyc;
            sb_check(1'b1);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int code, input bit expect_launch);
      if_freq     = 9'(code);
      freq_strobe = 1'b1;
      send_cyc    = cyc;
      if (expect_launch) exp_q.push_back(model(code));
      else if (!code_ok(code)) exp_q.push_back(err_ev());
      step(1);
      freq_strobe = 1'b0;
   endtask

   task automatic wait_strobe(input int budget);
      int s;
      int i;
      s = n_strobe;
      i = 0;
      while (n_strobe == s && i < budget) begin
         step(1);
         i++;
      end
      check("strobe_seen", 32'(n_strobe - s), 1);
   endtask

   task automatic wait_err(input int budget);
      int s;
      int i;
      s = n_err;
      i = 0;
      while (n_err == s && i < budget) begin
         step(1);
         i++;
      end
      check("err_seen", 32'(n_err - s), 1);
   endtask

   task automatic busy_ack();
      busy = 1'b1;
      step(3);
      busy = 1'b0;
   endtask

   task automatic wait_rst_hi();
      int i;
      i = 0;
      while (pll_reset !== 1'b1 && i < 20) begin
         step(1);
         i++;
      end
      check("rst_seen", 32'(pll_reset), 1);
      pll_lock = 1'b0;
   endtask

   // Returns on the first WAIT_LOCK cycle (pll_reset just fell).
   task automatic reset_width();
      int w;
      wait_rst_hi();
      w = 0;
      while (pll_reset === 1'b1 && w < 50) begin
         step(1);
         w++;
      end
      check("rst_width", 32'(w), 8);
   endtask

   // 2 synchronizer cycles + 16 stable cycles, visible after the 18th edge.
   task automatic lock_up(input int code);
      pll_lock = 1'b1;
      step(17);
      check("lock_early", 32'(locked), 0);
      step(1);
      check("lock_rise", 32'(locked), 1);
      check("cur_freq", 32'(cur_freq), 32'(code));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int s0;
      rst_n = 1'b1;
      #5 rst_n = 1'b0;
      step(2);
      check("rst_m", 32'(m), 0);
      check("rst_n_val", 32'(n), 50);
      check("rst_c0", 32'(c0), 0);
      check("rst_cur", 32'(cur_freq), 0);
      check("rst_flags", 32'({reconfig_strobe, pll_reset, locked, freq_err}), 0);
      rst_n = 1'b1;
      step(2);

      // Low code: deepest search, k = 8.
      send(3, 1);
      wait_strobe(40);
      check("lat_3", 32'(strobe_cyc - send_cyc), 10);
      check("m_3", 32'(m), 768);
      check("c0_3", 32'(c0), 256);
      busy_ack();
      reset_width();
      lock_up(3);

      // Upper edge and rejected codes.
      send(300, 1);
      wait_strobe(40);
      check("lat_300", 32'(strobe_cyc - send_cyc), 3);
      check("m_300", 32'(m), 600);
      check("c0_300", 32'(c0), 2);
      busy_ack();
      reset_width();
      lock_up(300);
      s0 = n_strobe;
      send(301, 0);
      wait_err(10);
      check("err_lat_301", 32'(err_cyc - send_cyc), 1);
      send(2, 0);
      wait_err(10);
      check("err_lat_2", 32'(err_cyc - send_cyc), 1);
      step(15);
      check("no_strobe_bad", 32'(n_strobe - s0), 0);
      check("locked_kept", 32'(locked), 1);
      check("cur_kept", 32'(cur_freq), 300);

      // Overlapping requests: 150 is overwritten by 200 while pending.
      send(100, 1);
      wait_strobe(40);
      busy = 1'b1;
      step(1);
      send(150, 0);
      send(200, 1);
      busy = 1'b0;
      reset_width();
      lock_up(100);
      wait_strobe(40);
      check("m_200", 32'(m), 800);
      check("c0_200", 32'(c0), 4);
      busy_ack();
      reset_width();
      lock_up(200);

      // Lock glitch at stable count 10.
      send(120, 1);
      wait_strobe(40);
      busy_ack();
      reset_width();
      pll_lock = 1'b1;
      step(12);
      pll_lock = 1'b0;
      step(1);
      pll_lock = 1'b1;
      step(17);
      check("glitch_early", 32'(locked), 0);
      step(1);
      check("glitch_rise", 32'(locked), 1);
      // Lock lost in IDLE drops locked after the synchronizer.
      pll_lock = 1'b0;
      step(2);
      check("drop_hold", 32'(locked), 1);
      step(1);
      check("drop_clear", 32'(locked), 0);

      // Busy never rises.
      send(250, 1);
      wait_strobe(40);
      exp_q.push_back(err_ev());
      wait_err(TMO + 50);
      check("busy_tmo_lat", 32'(err_cyc - strobe_cyc), TMO + 1);
      check("busy_tmo_lock", 32'(locked), 0);
      check("busy_tmo_cur", 32'(cur_freq), 120);

      // Lock never arrives.
      s0 = n_strobe;
      send(60, 1);
      wait_strobe(40);
      busy_ack();
      reset_width();
`ifdef PLL_RECFG_RETRY_EN
      exp_q.push_back(model(60));
      wait_strobe(TMO + 50);
      busy_ack();
      reset_width();
      check("retry_strobes", 32'(n_strobe - s0), 2);
`else
      check("noretry_strobes", 32'(n_strobe - s0), 1);
`endif
      exp_q.push_back(err_ev());
      wait_err(TMO + 50);
      check("lock_tmo_lock", 32'(locked), 0);
      check("lock_tmo_cur", 32'(cur_freq), 120);

      // Reset during PLL_RST with a pending request.
      send(90, 1);
      wait_strobe(40);
      busy_ack();
      wait_rst_hi();
      send(40, 0);
      rst_n = 1'b0;
      #1;
      check("arst_pll_reset", 32'(pll_reset), 0);
      check("arst_strobe", 32'(reconfig_strobe), 0);
      check("arst_m", 32'(m), 0);
      step(2);
      rst_n = 1'b1;
      s0 = n_strobe;
      step(40);
      check("arst_no_pending", 32'(n_strobe - s0), 0);
      check("arst_idle_rst", 32'(pll_reset), 0);

      check("sb_drained", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
